// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Shares the single synchronous write port of the register file between two
//   writeback requesters. p0 is the main pipeline writeback and normally wins.
//   p1 is the long-latency unit writeback (mul/div, load miss return). A small
//   starvation FSM forces one p1 grant after STARVE_LIMIT consecutive denials.
//   Grants are combinational, so a granted write lands in the register file on
//   the next rising i_clk edge. Writes to x0 complete the handshake but are
//   not forwarded as a write enable.
//
// Parameters
//   STARVE_LIMIT : consecutive denied cycles for p1 before boost (1..15)
//
// Ports
//   i_clk, i_rst_n               clock (rising edge), async active-low reset
//   i_p0_valid/o_p0_ready        p0 handshake, i_p0_waddr[4:0], i_p0_wdata[31:0]
//   i_p1_valid/o_p1_ready        p1 handshake, i_p1_waddr[4:0], i_p1_wdata[31:0]
//   o_rd_wen/o_rd_waddr/o_rd_wdata  register file write port
//   o_p1_boost                   high while the FSM is in BOOST (registered)
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p0_valid,
    output logic        o_p0_ready,
    input  logic [4:0]  i_p0_waddr,
    input  logic [31:0] i_p0_wdata,
    input  logic        i_p1_valid,
    output logic        o_p1_ready,
    input  logic [4:0]  i_p1_waddr,
    input  logic [31:0] i_p1_wdata,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata,
    output logic        o_p1_boost
);

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_BOOST  = 1'b1
    } mode_t;

    // Denial count at which the next denial triggers BOOST.
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    mode_t       mode_reg, mode_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        p0_gnt, p1_gnt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_reg     <= MODE_NORMAL;
            wait_cnt_reg <= 4'd0;
        end else begin
            mode_reg     <= mode_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Grant and next-state logic. Grants are gated by i_rst_n so that no
    // handshake can complete while reset is held, even with valid inputs.
    // -----------------------------------------------------------------------
    always_comb begin
        p0_gnt        = 1'b0;
        p1_gnt        = 1'b0;
        mode_next     = mode_reg;
        wait_cnt_next = wait_cnt_reg;

        if (i_rst_n) begin
            case (mode_reg)
                MODE_NORMAL: begin
                    if (i_p0_valid) begin
                        p0_gnt = 1'b1;
                        if (i_p1_valid) begin
                            // p1 denied this cycle
                            if (wait_cnt_reg >= LIMIT_M1) begin
                                mode_next     = MODE_BOOST;
                                wait_cnt_next = 4'd0;
                            end else begin
                                wait_cnt_next = wait_cnt_reg + 4'd1;
                            end
                        end else begin
                            wait_cnt_next = 4'd0;
                        end
                    end else begin
                        // p1 either granted or idle: both clear the count
                        p1_gnt        = i_p1_valid;
                        wait_cnt_next = 4'd0;
                    end
                end
                MODE_BOOST: begin
                    // p0 is stalled. Boost ends after one edge whether p1
                    // transferred or (protocol violation) dropped valid.
                    p1_gnt        = i_p1_valid;
                    mode_next     = MODE_NORMAL;
                    wait_cnt_next = 4'd0;
                end
                default: begin
                    mode_next     = MODE_NORMAL;
                    wait_cnt_next = 4'd0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write port mux. Zero when nothing is granted; x0 writes drop wen only.
    // -----------------------------------------------------------------------
    always_comb begin
        o_rd_wen   = 1'b0;
        o_rd_waddr = 5'd0;
        o_rd_wdata = 32'd0;
        if (p0_gnt) begin
            o_rd_wen   = (i_p0_waddr != 5'd0);
            o_rd_waddr = i_p0_waddr;
            o_rd_wdata = i_p0_wdata;
        end else if (p1_gnt) begin
            o_rd_wen   = (i_p1_waddr != 5'd0);
            o_rd_waddr = i_p1_waddr;
            o_rd_wdata = i_p1_wdata;
        end
    end

    assign o_p0_ready = p0_gnt;
    assign o_p1_ready = p1_gnt;
    assign o_p1_boost = (mode_reg == MODE_BOOST);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed scenarios followed by randomized traffic. The stimulus process
//   predicts each cycle's grant from the arbitration rules (p0 first, p1
//   forced through after STARVE_LIMIT consecutive denials) and pushes the
//   expected write into a queue. An independent monitor pops on every grant
//   the DUT presents and compares; idle cycles must show an all-zero port.
//   A bench-side register file captures DUT writes for end-of-run checks.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic [4:0]  p0_waddr = '0, p1_waddr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ready, p1_ready, rd_wen, p1_boost;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    rf_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_p0_valid (p0_valid),
        .o_p0_ready (p0_ready),
        .i_p0_waddr (p0_waddr),
        .i_p0_wdata (p0_wdata),
        .i_p1_valid (p1_valid),
        .o_p1_ready (p1_ready),
        .i_p1_waddr (p1_waddr),
        .i_p1_wdata (p1_wdata),
        .o_rd_wen   (rd_wen),
        .o_rd_waddr (rd_waddr),
        .o_rd_wdata (rd_wdata),
        .o_p1_boost (p1_boost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  rdy;    // {p1_ready, p0_ready}
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        boost;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          p1_wait = 0;    // consecutive cycles p1 has been valid and denied
    logic [31:0] tb_rf  [32] = '{default: 32'd0};
    logic [31:0] exp_rf [32] = '{default: 32'd0};

    always @(posedge clk) cyc <= cyc + 1;

    // Register file standing in for the real one: commits on the edge.
    always @(posedge clk) if (rd_wen) tb_rf[rd_waddr] <= rd_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (p0_ready || p1_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_grant", 64'({p1_ready, p0_ready}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                $display("txn cyc=%0d rdy=%b wen=%b addr=%0d data=%08h boost=%b",
                         cyc, {p1_ready, p0_ready}, rd_wen, rd_waddr, rd_wdata, p1_boost);
                chk("grant_cycle", 64'(cyc), 64'(e.cyc));
                chk("ready_pair", 64'({p1_ready, p0_ready}), 64'(e.rdy));
                chk("rd_wen", 64'(rd_wen), 64'(e.wen));
                chk("rd_waddr", 64'(rd_waddr), 64'(e.addr));
                chk("rd_wdata", 64'(rd_wdata), 64'(e.data));
                chk("p1_boost", 64'(p1_boost), 64'(e.boost));
            end
        end else begin
            chk("idle_port", 64'({rd_wen, rd_waddr, rd_wdata, p1_boost}), 64'(0));
            if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                chk("missed_grant", 64'(0), 64'(e.rdy));
            end
        end
    end

    // Drive one cycle (called at posedge+1), predict its grant, wait a cycle.
    task automatic drive_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               output logic g0, output logic g1);
        exp_t e;
        logic boost;
        p0_valid = v0; p0_waddr = a0; p0_wdata = d0;
        p1_valid = v1; p1_waddr = a1; p1_wdata = d1;
        boost = (p1_wait >= STARVE_LIMIT);
        g1 = v1 && (boost || !v0);
        g0 = v0 && !boost;
        if (g0 || g1) begin
            e.cyc   = cyc;
            e.rdy   = {g1, g0};
            e.addr  = g1 ? a1 : a0;
            e.data  = g1 ? d1 : d0;
            e.wen   = (e.addr != 5'd0);
            e.boost = boost;
            sb_q.push_back(e);
            if (e.wen) exp_rf[e.addr] = e.data;
        end
        p1_wait = (v1 && !g1) ? p1_wait + 1 : 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic g0, g1;
        logic pv0, pv1;
        logic [4:0]  pa0, pa1;
        logic [31:0] pd0, pd1;
        int dens;
        pv0 = 0; pv1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;

        // Reset held with requests pending: nothing may be granted.
        p0_valid = 1; p0_waddr = 5'd3; p0_wdata = 32'h1111_1111;
        p1_valid = 1; p1_waddr = 5'd4; p1_wdata = 32'h2222_2222;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({p0_ready, p1_ready, rd_wen, rd_waddr, rd_wdata, p1_boost}), 64'(0));
        rst_n = 1;

        // p0 alone to x5
        drive_cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, g0, g1);
        chk("rf_x5", 64'(tb_rf[5]), 64'(32'hDEADBEEF));

        // p1 alone to x31
        drive_cycle(0, 5'd0, 32'd0, 1, 5'd31, 32'h12345678, g0, g1);
        chk("rf_x31", 64'(tb_rf[31]), 64'(32'h12345678));

        // x0 write: handshake completes, no write
        drive_cycle(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, g0, g1);
        chk("rf_x0", 64'(tb_rf[0]), 64'(0));

        // Same address, both valid: p0 then p1, last writer wins
        drive_cycle(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, g0, g1);
        drive_cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'd2, g0, g1);
        chk("rf_x7", 64'(tb_rf[7]), 64'(2));

        // Starvation: p0 always valid with fresh data, p1 held until granted
        pv1 = 1;
        for (int j = 0; j < 6; j++) begin
            drive_cycle(1, 5'd10, 32'h1000 + 32'(j), pv1, 5'd9, 32'hA5A5_0001, g0, g1);
            if (g1) pv1 = 0;
        end

        // Reset asserted mid-boost
        for (int j = 0; j < STARVE_LIMIT; j++)
            drive_cycle(1, 5'd10, 32'h2000 + 32'(j), 1, 5'd12, 32'hBEEF_0012, g0, g1);
        chk("boost_before_reset", 64'({p1_boost, p1_ready, p0_ready}), 64'(3'b110));
        #2 rst_n = 0;
        #1;
        chk("reset_mid_boost", 64'({p0_ready, p1_ready, rd_wen, rd_waddr, rd_wdata, p1_boost}), 64'(0));
        p1_wait = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        pv1 = 1;
        for (int j = 0; j < 7; j++) begin
            drive_cycle(1, 5'd11, 32'h3000 + 32'(j), pv1, 5'd12, 32'hBEEF_0012, g0, g1);
            if (g1) pv1 = 0;
        end

        // Randomized traffic, heavy p0 load first then moderate
        for (int i = 0; i < 600; i++) begin
            dens = (i < 300) ? 90 : 50;
            if (!pv0 && int'($urandom_range(99)) < dens) begin
                pv0 = 1; pa0 = 5'($urandom_range(31)); pd0 = $urandom;
            end
            if (!pv1 && int'($urandom_range(99)) < 40) begin
                pv1 = 1; pa1 = 5'($urandom_range(31)); pd1 = $urandom;
            end
            drive_cycle(pv0, pa0, pd0, pv1, pa1, pd1, g0, g1);
            if (g0) pv0 = 0;
            if (g1) pv1 = 0;
        end
        repeat (3) drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, g0, g1);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        for (int r = 0; r < 32; r++)
            chk($sformatf("rf_final_x%0d", r), 64'(tb_rf[r]), 64'(exp_rf[r]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
